// File: rtl/fir_result_buffer.sv
// fir_result_buffer: DEPTH-entry show-ahead FIFO capturing FIR_SSE (out_filt, out_sse) pairs
// Ports: clk/rst (async active-low) clock and reset; clr sync flush;
//   ready/out_filt/out_sse push side from FIR_SSE; hold back-pressure request;
//   o_valid/o_filt/o_sse/o_ack consumer handshake; level/full occupancy;
//   overflow sticky drop flag; sample_cnt accepted pushes; sse_over sticky SSE flag.
// Optional feature: define SSE_LIMIT_EN to enable the SSE threshold comparator.
module fir_result_buffer #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter int          HOLD_LVL  = DEPTH - 2,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] SSE_LIMIT = 32'h3C23D70A
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ready,
  input  logic [DATA_W-1:0]        out_filt,
  input  logic [DATA_W-1:0]        out_sse,
  output logic                     hold,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_filt,
  output logic [DATA_W-1:0]        o_sse,
  input  logic                     o_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic                     sse_over
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_f [DEPTH];
  logic [DATA_W-1:0] mem_s [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_nx;
  logic push, pop;
  assign o_valid = level != '0;
  assign full = level == (AW+1)'(DEPTH);
  assign pop = o_valid & o_ack;
  // a pop in the same cycle frees the slot the push needs, so full does not block it
  assign push = ready & (!full | pop);
  assign level_nx = level + (AW+1)'(push) - (AW+1)'(pop);
  // gating by o_valid keeps the uncleared memory off the outputs while empty or in reset
  assign o_filt = o_valid ? mem_f[rd_ptr] : '0;
  assign o_sse = o_valid ? mem_s[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      hold       <= 1'b0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      hold       <= 1'b0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      level      <= level_nx;
      hold       <= level_nx >= (AW+1)'(HOLD_LVL);
      overflow   <= overflow | (ready & full & !pop);
      sample_cnt <= sample_cnt + CNT_W'(push);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_f[wr_ptr] <= out_filt;
      mem_s[wr_ptr] <= out_sse;
    end
`ifdef SSE_LIMIT_EN
  logic sse_hit;
  // NaN flags regardless of sign; otherwise only positive magnitudes above the limit
  assign sse_hit = (out_sse[30:23] == 8'hFF && out_sse[22:0] != '0) ||
                   (!out_sse[31] && out_sse[30:0] > SSE_LIMIT[30:0]);
  always_ff @(posedge clk or negedge rst)
    if (!rst) sse_over <= 1'b0;
    else sse_over <= clr ? 1'b0 : sse_over | (push & sse_hit);
`else
  assign sse_over = 1'b0;
`endif
endmodule

// File: tb/tb_fir_result_buffer.sv
// tb_fir_result_buffer: queue-model checked bench for fir_result_buffer
module tb_fir_result_buffer;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, clr = 0, ready = 0, o_ack = 0;
  logic [31:0] out_filt = 0, out_sse = 0;
  logic hold, o_valid, full, overflow, sse_over;
  logic [31:0] o_filt, o_sse;
  logic [4:0] level;
  logic [15:0] sample_cnt;
  int checks = 0, failures = 0;

  fir_result_buffer dut (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready), .out_filt(out_filt), .out_sse(out_sse),
    .hold(hold), .o_valid(o_valid), .o_filt(o_filt), .o_sse(o_sse), .o_ack(o_ack),
    .level(level), .full(full), .overflow(overflow), .sample_cnt(sample_cnt), .sse_over(sse_over)
  );

  always #5 clk = ~clk;

  logic [63:0] q[$];
  logic m_ovf = 0, m_hold = 0, m_sse = 0;
  logic [15:0] m_cnt = 0;

  function automatic logic sse_trip(input logic [31:0] s);
`ifdef SSE_LIMIT_EN
    return (s[30:23] == 8'hFF && s[22:0] != 0) || (!s[31] && s[30:0] > 31'h3C23D70A);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      q.delete(); m_ovf = 0; m_hold = 0; m_sse = 0; m_cnt = 0;
    end else begin
      automatic bit pp = q.size() > 0 && o_ack;
      automatic bit ps = ready && (q.size() < DEPTH || pp);
      if (ready && !ps) m_ovf = 1;
      if (pp) void'(q.pop_front());
      if (ps) begin
        q.push_back({out_filt, out_sse});
        m_cnt++;
        if (sse_trip(out_sse)) m_sse = 1;
      end
      m_hold = q.size() >= DEPTH - 2;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
    chk("level", 32'(level), q.size());
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("hold", 32'(hold), 32'(m_hold));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    chk("sse_over", 32'(sse_over), 32'(m_sse));
    if (q.size() > 0) begin
      chk("o_filt", o_filt, q[0][63:32]);
      chk("o_sse", o_sse, q[0][31:0]);
    end else if (!rst) begin
      chk("o_filt_rst", o_filt, 0);
      chk("o_sse_rst", o_sse, 0);
    end
  end

  task automatic cyc(input logic r, input logic a, input logic [31:0] f, input logic [31:0] s);
    ready = r; o_ack = a; out_filt = f; out_sse = s;
    @(posedge clk); #2;
  endtask

  task automatic flush();
    clr = 1; cyc(0, 0, 0, 0); clr = 0;
  endtask

  localparam logic SSE_ON =
`ifdef SSE_LIMIT_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    cyc(0, 0, 0, 0);
    chk("t1_valid", 32'(o_valid), 0);
    chk("t1_level", 32'(level), 0);
    chk("t1_filt", o_filt, 0);
    chk("t1_cnt", 32'(sample_cnt), 0);
    cyc(1, 1, 32'h3F800000, 32'h00000000);
    chk("t2_filt0", o_filt, 32'h3F800000);
    cyc(1, 1, 32'h40000000, 32'h3F800000);
    chk("t2_filt1", o_filt, 32'h40000000);
    cyc(1, 1, 32'h40400000, 32'h40000000);
    chk("t2_filt2", o_filt, 32'h40400000);
    chk("t2_sse2", o_sse, 32'h40000000);
    cyc(0, 1, 0, 0);
    chk("t2_level", 32'(level), 0);
    chk("t2_cnt", 32'(sample_cnt), 3);
    flush();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 100 + i, i);
      if (i == 12) chk("t3_hold13", 32'(hold), 0);
      if (i == 13) chk("t3_hold14", 32'(hold), 1);
      if (i == 14) chk("t3_notfull", 32'(full), 0);
    end
    chk("t3_full", 32'(full), 1);
    cyc(1, 0, 999, 999);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_cnt", 32'(sample_cnt), 16);
    chk("t3_head", o_filt, 100);
    flush();
    for (int i = 0; i < 16; i++) cyc(1, 0, 200 + i, 200 + i);
    cyc(1, 1, 300, 300);
    chk("t4_level", 32'(level), 16);
    chk("t4_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain", o_filt, i < 15 ? 201 + i : 300);
      cyc(0, 1, 0, 0);
    end
    chk("t4_empty", 32'(o_valid), 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 400 + i, i);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t5_level5", 32'(level), 5);
    o_ack = 0;
    #1 rst = 0;
    #1;
    chk("t5_async_level", 32'(level), 0);
    chk("t5_async_valid", 32'(o_valid), 0);
    chk("t5_async_filt", o_filt, 0);
    @(posedge clk); #2 rst = 1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 500 + i, i);
    clr = 1; cyc(1, 1, 600, 600); clr = 0;
    chk("t5_clr_level", 32'(level), 0);
    chk("t5_clr_valid", 32'(o_valid), 0);
    cyc(1, 1, 1, 32'h3C000000);
    chk("t6_below", 32'(sse_over), 0);
    cyc(1, 1, 2, 32'h3D000000);
    chk("t6_above", 32'(sse_over), 32'(SSE_ON));
    flush();
    cyc(1, 1, 3, 32'hBF800000);
    chk("t6_neg", 32'(sse_over), 0);
    cyc(1, 1, 4, 32'h7FC00000);
    chk("t6_nan", 32'(sse_over), 32'(SSE_ON));
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
